// File: rtl/jacobi_out_framer.sv
// Buffers 32-bit Jacobi result words and serialises each matrix result into a byte frame:
// SYNC_BYTE, payload LSB-first, and an XOR checksum byte when JACOBI_FRAMER_CHECKSUM_EN is defined.
module jacobi_out_framer #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_dat_i,
    input  logic        in_vld_i,
    output logic        in_rdy_o,
    input  logic        in_last_i,
    output logic [7:0]  out_dat_o,
    output logic        out_vld_o,
    input  logic        out_rdy_i,
    output logic        out_last_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

`ifdef JACOBI_FRAMER_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, SYNC, PAYLOAD, CSUM} state_t;
`else
    typedef enum logic [1:0] {IDLE, SYNC, PAYLOAD} state_t;
`endif

    logic [32:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [32:0]   head;

    state_t        state_q;
    logic [1:0]    idx_q;
    logic [7:0]    out_dat_q;
    logic          out_vld_q;
    logic          out_last_q;
`ifdef JACOBI_FRAMER_CHECKSUM_EN
    logic [7:0]    csum_q;
`endif

    logic          xfer;
    logic          adv;
    logic          tail;
    logic          load;
    logic [7:0]    byte_sel;

    // Pointers carry one extra bit so equal low bits with differing MSBs means full.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign in_rdy_o = !full;
    assign push     = in_vld_i && !full;
    assign head     = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {in_last_i, in_dat_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    assign xfer = out_vld_q && out_rdy_i;
    assign adv  = xfer || !out_vld_q;
`ifdef JACOBI_FRAMER_CHECKSUM_EN
    assign tail = 1'b0;
`else
    // Without a checksum byte, the last payload byte waits in PAYLOAD until it is taken.
    assign tail = out_last_q;
`endif

    // The SYNC handoff loads byte 0 directly so the frame has no bubble after the sync byte.
    assign load     = !empty && (((state_q == SYNC) && xfer) ||
                                 ((state_q == PAYLOAD) && adv && !tail));
    assign pop      = load && (idx_q == 2'd3);
    assign byte_sel = head[{idx_q, 3'b000} +: 8];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            out_dat_q  <= 8'h00;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
`ifdef JACOBI_FRAMER_CHECKSUM_EN
            csum_q     <= 8'h00;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        out_dat_q  <= SYNC_BYTE;
                        out_vld_q  <= 1'b1;
                        out_last_q <= 1'b0;
                        idx_q      <= 2'd0;
`ifdef JACOBI_FRAMER_CHECKSUM_EN
                        csum_q     <= 8'h00;
`endif
                        state_q    <= SYNC;
                    end
                end
                SYNC, PAYLOAD: begin
                    if (load) begin
                        out_dat_q <= byte_sel;
                        out_vld_q <= 1'b1;
                        idx_q     <= idx_q + 2'd1;
                        state_q   <= PAYLOAD;
`ifdef JACOBI_FRAMER_CHECKSUM_EN
                        csum_q    <= csum_q ^ byte_sel;
                        if ((idx_q == 2'd3) && head[32]) begin
                            state_q <= CSUM;
                        end
`else
                        if ((idx_q == 2'd3) && head[32]) begin
                            out_last_q <= 1'b1;
                        end
`endif
                    end else if ((state_q == PAYLOAD) && adv) begin
                        out_vld_q <= 1'b0;
                        if (tail) begin
                            out_last_q <= 1'b0;
                            state_q    <= IDLE;
                        end
                    end
                end
`ifdef JACOBI_FRAMER_CHECKSUM_EN
                CSUM: begin
                    // Entered while byte 3 is still in the register; checksum follows its transfer.
                    if (xfer) begin
                        if (out_last_q) begin
                            out_vld_q  <= 1'b0;
                            out_last_q <= 1'b0;
                            state_q    <= IDLE;
                        end else begin
                            out_dat_q  <= csum_q;
                            out_last_q <= 1'b1;
                        end
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_dat_o  = out_dat_q;
    assign out_vld_o  = out_vld_q;
    assign out_last_o = out_last_q;

endmodule

// File: tb/tb_jacobi_out_framer.sv
// Directed bench for jacobi_out_framer; expected byte streams come from a small frame model
// that follows the build's JACOBI_FRAMER_CHECKSUM_EN setting.
`timescale 1ns/1ps
module tb_jacobi_out_framer;

`ifdef JACOBI_FRAMER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    localparam logic [7:0] SYNC = 8'hA5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_dat_i = '0;
    logic        in_vld_i = 1'b0;
    logic        in_rdy_o;
    logic        in_last_i = 1'b0;
    logic [7:0]  out_dat_o;
    logic        out_vld_o;
    logic        out_rdy_i = 1'b1;
    logic        out_last_o;

    jacobi_out_framer #(.FIFO_DEPTH(16), .SYNC_BYTE(8'hA5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_dat_i  (in_dat_i),
        .in_vld_i  (in_vld_i),
        .in_rdy_o  (in_rdy_o),
        .in_last_i (in_last_i),
        .out_dat_o (out_dat_o),
        .out_vld_o (out_vld_o),
        .out_rdy_i (out_rdy_i),
        .out_last_o(out_last_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: never ready

    logic [7:0] cap_dat[$];
    bit         cap_last[$];
    int         cap_cyc[$];
    logic [7:0] exp_dat[$];
    bit         exp_last[$];
    logic [7:0] model_csum;
    int         cyc = 0;

    bit         stall_prev = 1'b0;
    logic [7:0] prev_dat;
    logic       prev_last;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Sink: drives out_rdy_i, records transfers, and checks outputs hold while stalled.
    always @(negedge clk) begin
        logic r;
        cyc++;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_vld", out_vld_o, 1);
                check("stall_dat", out_dat_o, prev_dat);
                check("stall_last", out_last_o, prev_last);
            end
            case (rdy_mode)
                0:       r = 1'b1;
                1:       r = 1'($urandom_range(0, 1));
                default: r = 1'b0;
            endcase
            out_rdy_i = r;
            if (out_vld_o && r) begin
                cap_dat.push_back(out_dat_o);
                cap_last.push_back(out_last_o);
                cap_cyc.push_back(cyc);
            end
            stall_prev = out_vld_o && !r;
            prev_dat   = out_dat_o;
            prev_last  = out_last_o;
        end
    end

    task automatic push(input logic [31:0] d, input logic l);
        int t = 0;
        @(negedge clk);
        in_dat_i  = d;
        in_last_i = l;
        in_vld_i  = 1'b1;
        while (!in_rdy_o && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!in_rdy_o) check("push_timeout", in_rdy_o, 1);
        @(posedge clk);
        #1 in_vld_i = 1'b0;
    endtask

    task automatic add_word(input logic [31:0] w, input bit first, input bit last);
        if (first) begin
            exp_dat.push_back(SYNC);
            exp_last.push_back(1'b0);
            model_csum = 8'h00;
        end
        for (int b = 0; b < 4; b++) begin
            exp_dat.push_back(w[8*b +: 8]);
            exp_last.push_back(last && (CS == 0) && (b == 3));
            model_csum ^= w[8*b +: 8];
        end
        if (last && (CS == 1)) begin
            exp_dat.push_back(model_csum);
            exp_last.push_back(1'b1);
        end
    endtask

    task automatic wait_bytes(input int n, input string tag);
        int t = 0;
        while (cap_dat.size() < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (cap_dat.size() < n) check({tag, "_timeout"}, cap_dat.size(), n);
        repeat (4) @(negedge clk);
    endtask

    task automatic compare_stream(input string tag, input int base);
        check({tag, "_len"}, cap_dat.size() - base, exp_dat.size());
        for (int i = 0; i < exp_dat.size() && (base + i) < cap_dat.size(); i++) begin
            check($sformatf("%s_dat%0d", tag, i), cap_dat[base+i], exp_dat[i]);
            check($sformatf("%s_last%0d", tag, i), cap_last[base+i], exp_last[i]);
        end
    endtask

    initial begin
        int base;
        int k;
        int lens[8];
        int total;
        lens = '{1, 3, 5, 2, 4, 1, 5, 2};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_vld", out_vld_o, 0);
        check("rst_dat", out_dat_o, 0);
        check("rst_last", out_last_o, 0);
        check("rst_rdy", in_rdy_o, 1);
        rst = 1'b0;

        // Two single-word frames back to back
        base = cap_dat.size();
        exp_dat.delete(); exp_last.delete();
        add_word(32'h11223344, 1, 1);
        add_word(32'hCAFEF00D, 1, 1);
        push(32'h11223344, 1'b1);
        push(32'hCAFEF00D, 1'b1);
        wait_bytes(base + exp_dat.size(), "single");
        compare_stream("single", base);
        k = base + 5 + CS;
        if (cap_cyc.size() > k) begin
            check("single_burst", cap_cyc[k-1] - cap_cyc[base], 4 + CS);
            check("single_gap", cap_cyc[k] - cap_cyc[k-1], 2);
        end

        // Two-word frame with sync latency and throughput
        base = cap_dat.size();
        exp_dat.delete(); exp_last.delete();
        add_word(32'h00000001, 1, 0);
        add_word(32'h80000000, 0, 1);
        push(32'h00000001, 1'b0);
        @(negedge clk);
        check("sync_early_vld", out_vld_o, 0);
        @(negedge clk);
        check("sync_vld", out_vld_o, 1);
        check("sync_dat", out_dat_o, SYNC);
        push(32'h80000000, 1'b1);
        wait_bytes(base + exp_dat.size(), "two");
        compare_stream("two", base);
        if (cap_cyc.size() == base + 9 + CS)
            check("two_burst", cap_cyc[base+8+CS] - cap_cyc[base], 8 + CS);

        // Mid-frame underrun
        base = cap_dat.size();
        exp_dat.delete(); exp_last.delete();
        add_word(32'hAABBCCDD, 1, 0);
        add_word(32'h01020304, 0, 1);
        push(32'hAABBCCDD, 1'b0);
        repeat (10) @(negedge clk);
        check("gap_vld", out_vld_o, 0);
        check("gap_cnt", cap_dat.size() - base, 5);
        push(32'h01020304, 1'b1);
        @(negedge clk);
        check("resume_early_vld", out_vld_o, 0);
        @(negedge clk);
        check("resume_vld", out_vld_o, 1);
        check("resume_dat", out_dat_o, 8'h04);
        wait_bytes(base + exp_dat.size(), "under");
        compare_stream("under", base);

        // Random sink readiness over 8 frames
        base = cap_dat.size();
        exp_dat.delete(); exp_last.delete();
        total = 0;
        rdy_mode = 1;
        for (int f = 0; f < 8; f++) begin
            for (int w = 0; w < lens[f]; w++) begin
                add_word({8'(f), 8'(w), 8'(~f), 8'(8'hC0 + w)}, w == 0, w == lens[f] - 1);
            end
        end
        for (int f = 0; f < 8; f++) begin
            for (int w = 0; w < lens[f]; w++) begin
                push({8'(f), 8'(w), 8'(~f), 8'(8'hC0 + w)}, w == lens[f] - 1);
            end
            total += 4 * lens[f] + 1 + CS;
        end
        check("rand_exp_len", exp_dat.size(), total);
        wait_bytes(base + total, "rand");
        rdy_mode = 0;
        repeat (2) @(negedge clk);
        compare_stream("rand", base);

        // Fill FIFO with sink stalled, then release
        @(posedge clk);
        #1 rdy_mode = 2;
        base = cap_dat.size();
        exp_dat.delete(); exp_last.delete();
        for (int i = 0; i < 20; i++) add_word(32'h10203040 + 32'h01010101 * i, i == 0, i == 19);
        for (int i = 0; i < 16; i++) push(32'h10203040 + 32'h01010101 * i, 1'b0);
        @(negedge clk);
        check("full_rdy", in_rdy_o, 0);
        @(posedge clk);
        #1 rdy_mode = 0;
        @(negedge clk);
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            check($sformatf("full_hold%0d", j), in_rdy_o, 0);
        end
        @(negedge clk);
        check("full_free", in_rdy_o, 1);
        for (int i = 16; i < 20; i++) push(32'h10203040 + 32'h01010101 * i, i == 19);
        wait_bytes(base + exp_dat.size(), "full");
        compare_stream("full", base);

        // Reset mid-frame
        @(posedge clk);
        #1 rdy_mode = 2;
        for (int i = 0; i < 4; i++) push(32'h55667788 + i, i == 3);
        @(posedge clk);
        #1;
        base = cap_dat.size();
        rdy_mode = 0;
        k = 0;
        while (cap_dat.size() < base + 4 && k < 100) begin
            @(posedge clk);
            #1 k++;
        end
        check("rst_mid_bytes", cap_dat.size() - base, 4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_vld", out_vld_o, 0);
        check("rst_mid_rdy", in_rdy_o, 1);
        check("rst_mid_last", out_last_o, 0);
        rst = 1'b0;
        base = cap_dat.size();
        repeat (3) @(negedge clk);
        check("rst_no_partial", out_vld_o, 0);
        exp_dat.delete(); exp_last.delete();
        add_word(32'h00000000, 1, 1);
        push(32'h00000000, 1'b1);
        wait_bytes(base + exp_dat.size(), "after_rst");
        compare_stream("after_rst", base);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
